// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester A/B handshakes plus the single-port dmem bus
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              a_req, a_wren, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data, a_q;
  logic              b_req, b_wren, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data, b_q;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data, q_dmem;
  logic              wren;
  modport slave (
    input  a_req, a_wren, a_addr, a_data, b_req, b_wren, b_addr, b_data, q_dmem,
    output a_gnt, a_rvalid, a_q, b_gnt, b_rvalid, b_q, address_dmem, data, wren
  );
  modport master (
    output a_req, a_wren, a_addr, a_data, b_req, b_wren, b_addr, b_data, q_dmem,
    input  a_gnt, a_rvalid, a_q, b_gnt, b_rvalid, b_q, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: A-priority dmem sharing with B anti-starvation and an owner-tagged read return pipe
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                clock,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);
  typedef enum logic {PRI_A, PRI_B} state_e;
  state_e                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic [READ_LATENCY-1:0] vld_q, own_q;
  logic [READ_LATENCY:0]   vld_s, own_s;
  logic                    a_win, b_win;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= PRI_A;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
  always_comb begin
    starve_d = (a_win && bus.b_req) ? starve_q + 4'd1 : 4'd0;
    state_d  = (state_q == PRI_A && a_win && bus.b_req &&
                5'(starve_q) + 5'd1 == 5'(STARVE_LIMIT)) ? PRI_B : PRI_A;
  end
  always_comb begin
    b_win            = !reset && bus.b_req && (state_q == PRI_B || !bus.a_req);
    a_win            = !reset && bus.a_req && !b_win;
    bus.a_gnt        = a_win;
    bus.b_gnt        = b_win;
    bus.address_dmem = a_win ? bus.a_addr : b_win ? bus.b_addr : '0;
    bus.data         = a_win ? bus.a_data : b_win ? bus.b_data : '0;
    bus.wren         = a_win ? bus.a_wren : b_win ? bus.b_wren : 1'b0;
    bus.a_rvalid     = !reset && vld_q[READ_LATENCY-1] && !own_q[READ_LATENCY-1];
    bus.b_rvalid     = !reset && vld_q[READ_LATENCY-1] && own_q[READ_LATENCY-1];
    bus.a_q          = bus.q_dmem;
    bus.b_q          = bus.q_dmem;
  end
  // Each granted read carries its owner down a shift pipe matched to the dmem latency
  assign vld_s = {vld_q, (a_win || b_win) && !bus.wren};
  assign own_s = {own_q, b_win};
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_s[READ_LATENCY-1:0];
      own_q <= own_s[READ_LATENCY-1:0];
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios then constrained-random traffic against a behavioural model
module tb_dmem_port_arbiter;
  localparam int SL = 4;
  localparam int RL = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus();
  dmem_port_arbiter #(.STARVE_LIMIT(SL), .READ_LATENCY(RL)) dut (.clock(clk), .reset(rst), .bus(bus));
  logic [31:0] dm [4096] = '{default: 32'h0};
  logic [31:0] qp [RL];
  always @(posedge clk) begin
    if (bus.wren) dm[bus.address_dmem] <= bus.data;
    qp[0] <= dm[bus.address_dmem];
    for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
  end
  assign bus.q_dmem = qp[RL-1];
  typedef struct {int due; bit own; logic [31:0] d;} rd_t;
  rd_t pend[$];
  logic [31:0] ref_mem [int];
  bit m_pri_b = 1'b0;
  int streak = 0, cyc_n = 0, win = 0, errs = 0, checks = 0;
  logic [1:0] dut_win;
  logic dut_arv, dut_brv;
  logic [31:0] dut_aq, dut_bq;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask
  task automatic drive(bit ar, bit aw, logic [11:0] aa, logic [31:0] ad,
                       bit br, bit bw, logic [11:0] ba, logic [31:0] bd);
    bus.a_req = ar; bus.a_wren = aw; bus.a_addr = aa; bus.a_data = ad;
    bus.b_req = br; bus.b_wren = bw; bus.b_addr = ba; bus.b_data = bd;
  endtask
  task automatic cyc();
    bit ear, ebr;
    logic [31:0] eq;
    @(negedge clk);
    win = 0;
    if (!rst) win = (m_pri_b && bus.b_req) ? 2 : bus.a_req ? 1 : bus.b_req ? 2 : 0;
    ear = 0; ebr = 0; eq = 'x;
    if (!rst && pend.size() > 0 && pend[0].due == cyc_n) begin
      ear = !pend[0].own; ebr = pend[0].own; eq = pend[0].d;
      void'(pend.pop_front());
    end
    chk("a_gnt", 64'(bus.a_gnt), 64'(win == 1));
    chk("b_gnt", 64'(bus.b_gnt), 64'(win == 2));
    chk("wren", 64'(bus.wren), 64'(win == 1 ? bus.a_wren : win == 2 ? bus.b_wren : 1'b0));
    chk("addr", 64'(bus.address_dmem), 64'(win == 1 ? bus.a_addr : win == 2 ? bus.b_addr : 12'h0));
    chk("data", 64'(bus.data), 64'(win == 1 ? bus.a_data : win == 2 ? bus.b_data : 32'h0));
    chk("a_rvalid", 64'(bus.a_rvalid), 64'(ear));
    chk("b_rvalid", 64'(bus.b_rvalid), 64'(ebr));
    if (ear) chk("a_q", 64'(bus.a_q), 64'(eq));
    if (ebr) chk("b_q", 64'(bus.b_q), 64'(eq));
    dut_win = {bus.b_gnt, bus.a_gnt};
    dut_arv = bus.a_rvalid; dut_brv = bus.b_rvalid;
    dut_aq = bus.a_q; dut_bq = bus.b_q;
    @(posedge clk);
    if (rst) begin
      m_pri_b = 0; streak = 0; pend.delete();
    end else begin
      if (win == 1 && bus.b_req) streak++; else streak = 0;
      m_pri_b = !m_pri_b && streak == SL;
      if (win != 0) begin
        int a = int'(win == 1 ? bus.a_addr : bus.b_addr);
        if (win == 1 ? bus.a_wren : bus.b_wren)
          ref_mem[a] = win == 1 ? bus.a_data : bus.b_data;
        else
          pend.push_back('{cyc_n + RL, win == 2, ref_mem.exists(a) ? ref_mem[a] : 32'h0});
      end
    end
    cyc_n++;
    #1;
  endtask
  initial begin
    drive(1, 0, 12'h0, 0, 1, 0, 12'h0, 0);
    rst = 1;
    repeat (2) begin
      cyc();
      chk("s1_rst_gnt", 64'(dut_win), 64'd0);
    end
    rst = 0;
    cyc();
    chk("s1_first_a", 64'(dut_win), 64'd1);
    drive(1, 1, 12'h010, 32'hDEAD_BEEF, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 12'h010, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("s2_arv", 64'(dut_arv), 64'd1);
    chk("s2_aq", 64'(dut_aq), 64'hDEAD_BEEF);
    chk("s2_brv", 64'(dut_brv), 64'd0);
    cyc();
    drive(1, 0, 12'h100, 0, 1, 0, 12'h200, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("s3_pattern", 64'(dut_win), (i % 5 == 0) ? 64'd2 : 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 12'h100, 0, 1, 0, 12'h200, 0);
    repeat (4) cyc();
    drive(1, 0, 12'h100, 0, 0, 0, 0, 0);
    cyc();
    chk("s5_drop_a", 64'(dut_win), 64'd1);
    drive(1, 0, 12'h100, 0, 1, 0, 12'h200, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("s5_restart", 64'(dut_win), i == 5 ? 64'd2 : 64'd1);
    end
    drive(1, 1, 12'h001, 32'h11, 0, 0, 0, 0);
    cyc();
    drive(1, 1, 12'h002, 32'h22, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 12'h001, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 0, 12'h002, 0);
    cyc();
    chk("s4_arv", 64'(dut_arv), 64'd1);
    chk("s4_aq", 64'(dut_aq), 64'h11);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("s4_brv", 64'(dut_brv), 64'd1);
    chk("s4_bq", 64'(dut_bq), 64'h22);
    drive(1, 0, 12'h010, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    cyc();
    chk("s6_rst_arv", 64'(dut_arv), 64'd0);
    rst = 0;
    drive(1, 0, 12'h0, 0, 1, 0, 12'h0, 0);
    cyc();
    chk("s6_post_arv", 64'(dut_arv), 64'd0);
    chk("s6_first_a", 64'(dut_win), 64'd1);
    for (int i = 0; i < 500; i++) begin
      if (!bus.a_req || win == 1 || rst)
        drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 12'($urandom_range(0, 15)), $urandom,
              bus.b_req, bus.b_wren, bus.b_addr, bus.b_data);
      if (!bus.b_req || win == 2 || rst) begin
        bus.b_req = $urandom_range(0, 2) != 0; bus.b_wren = $urandom_range(0, 1) == 1;
        bus.b_addr = 12'($urandom_range(0, 15)); bus.b_data = $urandom;
      end
      rst = $urandom_range(0, 60) == 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
